// File: rtl/always_prop_monitor.sv
// Multi-channel checker: after a falling edge of sig[i], sig[i] must stay low over a window.
// Optional per-channel arm counters are enabled with ALWAYS_PROP_MONITOR_COVER_EN.
module always_prop_monitor #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              en_i,
   input  logic [NUM_CH-1:0] sig_i,
   input  logic [CNT_W-1:0]  cfg_lo_i,
   input  logic [CNT_W-1:0]  cfg_hi_i,
   input  logic              cfg_unbounded_i,
   input  logic              cfg_strong_i,
   input  logic              end_check_i,
   input  logic              clr_sticky_i,
   output logic [NUM_CH-1:0] active_o,
   output logic [NUM_CH-1:0] pass_pulse_o,
   output logic [NUM_CH-1:0] fail_pulse_o,
   output logic [NUM_CH-1:0] fail_sticky_o,
   output logic [CNT_W-1:0]  fail_count_o
`ifdef ALWAYS_PROP_MONITOR_COVER_EN
   ,
   output logic [NUM_CH*CNT_W-1:0] arm_count_o
`endif
);

   localparam int unsigned SumW = CNT_W + $clog2(NUM_CH + 1);

   typedef enum logic {StIdle, StActive} ch_state_e;

   ch_state_e         state_q [NUM_CH];
   ch_state_e         state_d [NUM_CH];
   logic [CNT_W-1:0]  off_q   [NUM_CH];
   logic [CNT_W-1:0]  off_d   [NUM_CH];
   logic [CNT_W-1:0]  lo_q    [NUM_CH];
   logic [CNT_W-1:0]  lo_d    [NUM_CH];
   logic [CNT_W-1:0]  hi_q    [NUM_CH];
   logic [CNT_W-1:0]  hi_d    [NUM_CH];
   logic [NUM_CH-1:0] unb_q, unb_d;
   logic [NUM_CH-1:0] strong_q, strong_d;
   logic [NUM_CH-1:0] prev_sig_q;
   logic [NUM_CH-1:0] fell;
   logic [NUM_CH-1:0] active_q, active_d;
   logic [NUM_CH-1:0] pass_q, pass_d;
   logic [NUM_CH-1:0] fail_q, fail_d;
   logic [NUM_CH-1:0] sticky_q, sticky_d;
   logic [CNT_W-1:0]  fail_count_q, fail_count_d;
   logic [SumW-1:0]   fail_sum;
   logic [CNT_W-1:0]  cfg_hi_eff;

   assign fell       = prev_sig_q & ~sig_i;
   assign cfg_hi_eff = (cfg_lo_i > cfg_hi_i) ? cfg_lo_i : cfg_hi_i;

   // off_q holds the offset of the sample taken at the next edge; the arm edge is offset 0.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]  = state_q[i];
         off_d[i]    = off_q[i];
         lo_d[i]     = lo_q[i];
         hi_d[i]     = hi_q[i];
         unb_d[i]    = unb_q[i];
         strong_d[i] = strong_q[i];
         pass_d[i]   = 1'b0;
         fail_d[i]   = 1'b0;
         unique case (state_q[i])
            StIdle: begin
               if (en_i && fell[i]) begin
                  lo_d[i]     = cfg_lo_i;
                  hi_d[i]     = cfg_hi_eff;
                  unb_d[i]    = cfg_unbounded_i;
                  strong_d[i] = cfg_strong_i & ~cfg_unbounded_i;
                  // A zero-length bounded window completes on the arm sample itself.
                  if (!cfg_unbounded_i && cfg_hi_eff == '0) begin
                     pass_d[i] = 1'b1;
                  end else begin
                     state_d[i] = StActive;
                     off_d[i]   = CNT_W'(1);
                  end
               end
            end
            StActive: begin
               if (sig_i[i] && off_q[i] >= lo_q[i] && (unb_q[i] || off_q[i] <= hi_q[i])) begin
                  fail_d[i]  = 1'b1;
                  state_d[i] = StIdle;
               end else if (end_check_i) begin
                  fail_d[i]  = strong_q[i];
                  pass_d[i]  = ~strong_q[i];
                  state_d[i] = StIdle;
               end else if (!unb_q[i] && off_q[i] == hi_q[i]) begin
                  pass_d[i]  = 1'b1;
                  state_d[i] = StIdle;
               end else if (off_q[i] != '1) begin
                  off_d[i] = off_q[i] + CNT_W'(1);
               end
            end
            default: state_d[i] = StIdle;
         endcase
         active_d[i] = (state_d[i] == StActive);
      end
   end

   always_comb begin
      fail_sum = SumW'(fail_count_q);
      for (int i = 0; i < NUM_CH; i++) begin
         fail_sum = fail_sum + SumW'(fail_d[i]);
      end
      if (clr_sticky_i) begin
         fail_count_d = '0;
      end else if (|fail_sum[SumW-1:CNT_W]) begin
         fail_count_d = '1;
      end else begin
         fail_count_d = fail_sum[CNT_W-1:0];
      end
      // A fail in the clearing cycle must not be lost from the sticky flags.
      sticky_d = (clr_sticky_i ? '0 : sticky_q) | fail_d;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StIdle;
            off_q[i]   <= '0;
            lo_q[i]    <= '0;
            hi_q[i]    <= '0;
         end
         unb_q        <= '0;
         strong_q     <= '0;
         prev_sig_q   <= '0;
         active_q     <= '0;
         pass_q       <= '0;
         fail_q       <= '0;
         sticky_q     <= '0;
         fail_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            off_q[i]   <= off_d[i];
            lo_q[i]    <= lo_d[i];
            hi_q[i]    <= hi_d[i];
         end
         unb_q        <= unb_d;
         strong_q     <= strong_d;
         prev_sig_q   <= sig_i;
         active_q     <= active_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         sticky_q     <= sticky_d;
         fail_count_q <= fail_count_d;
      end
   end

   assign active_o      = active_q;
   assign pass_pulse_o  = pass_q;
   assign fail_pulse_o  = fail_q;
   assign fail_sticky_o = sticky_q;
   assign fail_count_o  = fail_count_q;

`ifdef ALWAYS_PROP_MONITOR_COVER_EN
   logic [CNT_W-1:0]  arm_cnt_q [NUM_CH];
   logic [CNT_W-1:0]  arm_cnt_d [NUM_CH];
   logic [NUM_CH-1:0] arm_now;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         arm_now[i] = (state_q[i] == StIdle) & en_i & fell[i];
         if (clr_sticky_i) begin
            arm_cnt_d[i] = '0;
         end else if (arm_now[i] && arm_cnt_q[i] != '1) begin
            arm_cnt_d[i] = arm_cnt_q[i] + CNT_W'(1);
         end else begin
            arm_cnt_d[i] = arm_cnt_q[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (!rst_ni) begin
            arm_cnt_q[i] <= '0;
         end else begin
            arm_cnt_q[i] <= arm_cnt_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_arm_out
      assign arm_count_o[g*CNT_W +: CNT_W] = arm_cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_always_prop_monitor.sv
// Randomized and directed bench for always_prop_monitor against a timestamp-based window model.
module tb_always_prop_monitor;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 8;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b0;
   logic              en_i = 1'b0;
   logic [NUM_CH-1:0] sig_i = '0;
   logic [CNT_W-1:0]  cfg_lo_i = '0;
   logic [CNT_W-1:0]  cfg_hi_i = '0;
   logic              cfg_unbounded_i = 1'b0;
   logic              cfg_strong_i = 1'b0;
   logic              end_check_i = 1'b0;
   logic              clr_sticky_i = 1'b0;
   logic [NUM_CH-1:0] active_o, pass_pulse_o, fail_pulse_o, fail_sticky_o;
   logic [CNT_W-1:0]  fail_count_o;
`ifdef ALWAYS_PROP_MONITOR_COVER_EN
   logic [NUM_CH*CNT_W-1:0] arm_count_o;
`endif

   always #5 clk_i = ~clk_i;

   always_prop_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .en_i            (en_i),
      .sig_i           (sig_i),
      .cfg_lo_i        (cfg_lo_i),
      .cfg_hi_i        (cfg_hi_i),
      .cfg_unbounded_i (cfg_unbounded_i),
      .cfg_strong_i    (cfg_strong_i),
      .end_check_i     (end_check_i),
      .clr_sticky_i    (clr_sticky_i),
      .active_o        (active_o),
      .pass_pulse_o    (pass_pulse_o),
      .fail_pulse_o    (fail_pulse_o),
      .fail_sticky_o   (fail_sticky_o),
      .fail_count_o    (fail_count_o)
`ifdef ALWAYS_PROP_MONITOR_COVER_EN
      ,
      .arm_count_o     (arm_count_o)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: each open window remembers the cycle it armed; offset = now - arm cycle.
   int         cyc = 0;
   bit   [3:0] m_on = '0;
   logic [3:0] m_prev = '0;
   int         m_arm [4];
   int         m_lo  [4];
   int         m_hi  [4];
   bit         m_unb [4];
   bit         m_str [4];
   logic [3:0] e_active = '0, e_pass = '0, e_fail = '0, e_sticky = '0;
   int         e_count = 0;

   task automatic model_step();
      logic [3:0] ep, ef;
      int j;
      ep = '0;
      ef = '0;
      if (!rst_ni) begin
         m_on = '0;
         m_prev = '0;
         e_sticky = '0;
         e_count = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m_on[i]) begin
               j = cyc - m_arm[i];
               if (j > 255) j = 255;
               if (sig_i[i] && j >= m_lo[i] && (m_unb[i] || j <= m_hi[i])) begin
                  ef[i] = 1'b1;
                  m_on[i] = 1'b0;
               end else if (end_check_i) begin
                  if (m_str[i] && !m_unb[i]) ef[i] = 1'b1;
                  else ep[i] = 1'b1;
                  m_on[i] = 1'b0;
               end else if (!m_unb[i] && j == m_hi[i]) begin
                  ep[i] = 1'b1;
                  m_on[i] = 1'b0;
               end
            end else if (en_i && m_prev[i] && !sig_i[i]) begin
               m_arm[i] = cyc;
               m_lo[i]  = int'(cfg_lo_i);
               m_hi[i]  = (cfg_lo_i > cfg_hi_i) ? int'(cfg_lo_i) : int'(cfg_hi_i);
               m_unb[i] = cfg_unbounded_i;
               m_str[i] = cfg_strong_i;
               if (!cfg_unbounded_i && m_hi[i] == 0) ep[i] = 1'b1;
               else m_on[i] = 1'b1;
            end
         end
         e_sticky = (clr_sticky_i ? 4'b0 : e_sticky) | ef;
         e_count  = clr_sticky_i ? 0 : e_count + $countones(ef);
         if (e_count > 255) e_count = 255;
         m_prev = sig_i;
      end
      e_active = m_on;
      e_pass = ep;
      e_fail = ef;
      cyc++;
   endtask

   task automatic step();
      model_step();
      @(posedge clk_i);
      #1;
      check_eq("active", 32'(active_o), 32'(e_active));
      check_eq("pass_pulse", 32'(pass_pulse_o), 32'(e_pass));
      check_eq("fail_pulse", 32'(fail_pulse_o), 32'(e_fail));
      check_eq("fail_sticky", 32'(fail_sticky_o), 32'(e_sticky));
      check_eq("fail_count", 32'(fail_count_o), 32'(e_count));
   endtask

   task automatic drive(input logic [3:0] s, input int n);
      sig_i = s;
      repeat (n) step();
   endtask

   initial begin
      drive(4'b0000, 2);
      check_eq("rst_outputs", {active_o, pass_pulse_o, fail_pulse_o, fail_sticky_o, fail_count_o}, 0);

      // Weak unbounded, lo=0: clean window closed by end_check.
      rst_ni = 1'b1; en_i = 1'b1;
      cfg_unbounded_i = 1'b1; cfg_lo_i = 8'd0; cfg_hi_i = 8'd0; cfg_strong_i = 1'b0;
      drive(4'b0001, 5);
      drive(4'b0000, 1);
      check_eq("unb_arm_active", 32'(active_o), 32'h1);
      drive(4'b0000, 19);
      check_eq("unb_no_fail", 32'(fail_count_o), 32'h0);
      end_check_i = 1'b1; drive(4'b0000, 1); end_check_i = 1'b0;
      check_eq("unb_end_pass", 32'(pass_pulse_o), 32'h1);
      drive(4'b0000, 1);
      check_eq("unb_pass_one_cycle", 32'(pass_pulse_o), 32'h0);

      // Glitch at offset 1, then re-arm on the next fall.
      drive(4'b0001, 1); drive(4'b0000, 1); drive(4'b0001, 1);
      check_eq("glitch_fail", 32'(fail_pulse_o), 32'h1);
      check_eq("glitch_count", 32'(fail_count_o), 32'h1);
      drive(4'b0000, 1);
      check_eq("glitch_fail_once", 32'(fail_pulse_o), 32'h0);
      check_eq("glitch_rearm", 32'(active_o), 32'h1);
      end_check_i = 1'b1; drive(4'b0000, 1); end_check_i = 1'b0;

      // Bounded lo=2 hi=4: don't-care high at offset 1, then violation at offset 3.
      cfg_unbounded_i = 1'b0; cfg_lo_i = 8'd2; cfg_hi_i = 8'd4;
      drive(4'b0001, 1); drive(4'b0000, 1); drive(4'b0001, 1); drive(4'b0000, 2);
      check_eq("bnd_no_early_pass", 32'(pass_pulse_o), 32'h0);
      drive(4'b0000, 1);
      check_eq("bnd_pass", 32'(pass_pulse_o), 32'h1);
      drive(4'b0001, 1); drive(4'b0000, 3); drive(4'b0001, 1);
      check_eq("bnd_fail", {pass_pulse_o, fail_pulse_o}, 32'h01);
      check_eq("bnd_count", 32'(fail_count_o), 32'h2);
      drive(4'b0000, 1);
      end_check_i = 1'b1; drive(4'b0000, 1); end_check_i = 1'b0;

      // Strong vs weak bounded, end_check at offset 3.
      cfg_lo_i = 8'd0; cfg_hi_i = 8'd10; cfg_strong_i = 1'b1;
      drive(4'b0001, 1); drive(4'b0000, 3);
      end_check_i = 1'b1; drive(4'b0000, 1); end_check_i = 1'b0;
      check_eq("strong_end_fail", {pass_pulse_o, fail_pulse_o}, 32'h01);
      cfg_strong_i = 1'b0;
      drive(4'b0001, 1); drive(4'b0000, 3);
      end_check_i = 1'b1; drive(4'b0000, 1); end_check_i = 1'b0;
      check_eq("weak_end_pass", {pass_pulse_o, fail_pulse_o}, 32'h10);

      // Simultaneous fails, saturation and clear.
      cfg_unbounded_i = 1'b1;
      clr_sticky_i = 1'b1; drive(4'b0000, 1); clr_sticky_i = 1'b0;
      check_eq("clr_count", 32'(fail_count_o), 32'h0);
      drive(4'b0101, 1); drive(4'b0000, 1); drive(4'b0101, 1);
      check_eq("dual_fail", 32'(fail_pulse_o), 32'h5);
      check_eq("dual_count", 32'(fail_count_o), 32'h2);
      repeat (126) begin
         drive(4'b0000, 1); drive(4'b0101, 1);
      end
      check_eq("count_254", 32'(fail_count_o), 32'd254);
      drive(4'b0000, 1); drive(4'b0101, 1);
      check_eq("count_sat", 32'(fail_count_o), 32'd255);
      drive(4'b0000, 1); drive(4'b0101, 1);
      check_eq("count_hold_sat", 32'(fail_count_o), 32'd255);
      clr_sticky_i = 1'b1; drive(4'b0101, 1); clr_sticky_i = 1'b0;
      check_eq("clr_after_sat", {fail_sticky_o, fail_count_o}, 32'h0);

      // Reset mid-window, then sig held high through reset.
      drive(4'b0000, 2);
      rst_ni = 1'b0; drive(4'b0000, 1);
      check_eq("rst_mid_window", {active_o, pass_pulse_o, fail_pulse_o}, 32'h0);
      drive(4'b0001, 1);
      rst_ni = 1'b1; drive(4'b0001, 1);
      check_eq("held_high_no_edge", 32'(active_o), 32'h0);
      drive(4'b0000, 1);
      check_eq("held_high_arms", 32'(active_o), 32'h1);

      for (int k = 0; k < 3000; k++) begin
         rst_ni          = ($urandom_range(0, 299) != 0);
         en_i            = ($urandom_range(0, 9) != 0);
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 99) < 12) sig_i[b] = ~sig_i[b];
         end
         cfg_lo_i        = 8'($urandom_range(0, 5));
         cfg_hi_i        = 8'($urandom_range(0, 9));
         cfg_unbounded_i = ($urandom_range(0, 3) == 0);
         cfg_strong_i    = ($urandom_range(0, 1) == 1);
         end_check_i     = ($urandom_range(0, 39) == 0);
         clr_sticky_i    = ($urandom_range(0, 59) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
